// File: rtl/wb_unit_pkg.sv
// Shared definitions for the writeback stage: load encodings, FSM states and
// the funct3 legality helper used by the load formatter.
package wb_unit_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

  function automatic logic f3_is_legal(input logic [2:0] f3);
    logic legal;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/wb_unit_load_fmt.sv
// Load data formatter: picks the byte/half/word addressed by addr_lo out of the
// raw aligned word and sign- or zero-extends it; flags unsupported funct3.
module wb_unit_load_fmt
  import wb_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] raw_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o,
  output logic            illegal_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Halves are naturally aligned upstream, so only addr_lo[1] picks the half.
  assign byte_s    = raw_i[{addr_lo_i, 3'b000} +: 8];
  assign half_s    = raw_i[{addr_lo_i[1], 4'b0000} +: 16];
  assign illegal_o = !f3_is_legal(funct3_i);

  // Extension of the selected lane to the full datapath width.
  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH:   data_o = {{(XLEN-16){half_s[15]}}, half_s};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_s};
      F3_LW:   data_o = raw_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: sole writer of the integer register file. Retires ALU results
// directly, waits for one outstanding load at a time and exports a busy scoreboard.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid_i,
  output logic            exu_ready_o,
  input  logic [4:0]      exu_rd_addr_i,
  input  logic            exu_rd_wen_i,
  input  logic            exu_is_load_i,
  input  logic [2:0]      exu_funct3_i,
  input  logic [1:0]      exu_addr_lo_i,
  input  logic [XLEN-1:0] exu_result_i,
  input  logic            lsu_rvalid_i,
  input  logic [XLEN-1:0] lsu_rdata_i,
  input  logic            lsu_rerr_i,
  output logic            rd_wen_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [31:0]     busy_mask_o,
  output logic            wb_done_o,
  output logic            load_err_o
);

  localparam logic        TIMEOUT_EN  = (LOAD_TIMEOUT != 0);
  localparam logic [31:0] TIMEOUT_LIM = 32'(LOAD_TIMEOUT);

  wb_state_e       state_q, state_d;
  logic [31:0]     cnt_q, cnt_d, cnt_inc_s;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            ld_wen_q, ld_wen_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_lo_q, ld_lo_d;
  logic            rd_wen_q, rd_wen_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [31:0]     busy_q, busy_d;
  logic            wb_done_q, wb_done_d;
  logic            load_err_q, load_err_d;
  logic [XLEN-1:0] fmt_data_s;
  logic            fmt_illegal_s;

  wb_unit_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .raw_i     (lsu_rdata_i),
    .funct3_i  (ld_f3_q),
    .addr_lo_i (ld_lo_q),
    .data_o    (fmt_data_s),
    .illegal_o (fmt_illegal_s)
  );

  assign cnt_inc_s = cnt_q + 32'd1;

  // Next-state, scoreboard and writeback computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_wen_d   = ld_wen_q;
    ld_f3_d    = ld_f3_q;
    ld_lo_d    = ld_lo_q;
    rd_wen_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    busy_d     = busy_q;
    wb_done_d  = 1'b0;
    load_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 32'd0;
        if (exu_valid_i && exu_is_load_i) begin
          ld_rd_d  = exu_rd_addr_i;
          ld_wen_d = exu_rd_wen_i;
          ld_f3_d  = exu_funct3_i;
          ld_lo_d  = exu_addr_lo_i;
          state_d  = ST_WAIT_LOAD;
          if (exu_rd_wen_i && (exu_rd_addr_i != 5'd0)) begin
            busy_d = 32'd1 << exu_rd_addr_i;
          end else begin
            busy_d = 32'd0;
          end
        end else if (exu_valid_i) begin
          wb_done_d = 1'b1;
          if (exu_rd_wen_i && (exu_rd_addr_i != 5'd0)) begin
            rd_wen_d  = 1'b1;
            rd_addr_d = exu_rd_addr_i;
            rd_data_d = exu_result_i;
          end else begin
            rd_wen_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LOAD: begin
        // A response in the expiry cycle still retires normally.
        if (lsu_rvalid_i) begin
          state_d   = ST_IDLE;
          busy_d    = 32'd0;
          wb_done_d = 1'b1;
          cnt_d     = 32'd0;
          if (lsu_rerr_i || fmt_illegal_s) begin
            load_err_d = 1'b1;
          end else if (ld_wen_q && (ld_rd_q != 5'd0)) begin
            rd_wen_d  = 1'b1;
            rd_addr_d = ld_rd_q;
            rd_data_d = fmt_data_s;
          end else begin
            rd_wen_d  = 1'b0;
          end
        end else if (TIMEOUT_EN && (cnt_inc_s == TIMEOUT_LIM)) begin
          state_d    = ST_IDLE;
          busy_d     = 32'd0;
          wb_done_d  = 1'b1;
          load_err_d = 1'b1;
          cnt_d      = 32'd0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 32'd0;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // State, scoreboard and registered register-file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 32'd0;
      ld_rd_q    <= 5'd0;
      ld_wen_q   <= 1'b0;
      ld_f3_q    <= 3'd0;
      ld_lo_q    <= 2'd0;
      rd_wen_q   <= 1'b0;
      rd_addr_q  <= 5'd0;
      rd_data_q  <= '0;
      busy_q     <= 32'd0;
      wb_done_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_wen_q   <= ld_wen_d;
      ld_f3_q    <= ld_f3_d;
      ld_lo_q    <= ld_lo_d;
      rd_wen_q   <= rd_wen_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      wb_done_q  <= wb_done_d;
      load_err_q <= load_err_d;
    end
  end

  assign exu_ready_o = (state_q == ST_IDLE);
  assign rd_wen_o    = rd_wen_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign busy_mask_o = busy_q;
  assign wb_done_o   = wb_done_q;
  assign load_err_o  = load_err_q;

endmodule
